// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: the arbiter's cache-side and RAM-side signals in one bundle.
//
// The slave modport is the arbiter's view:
//   inputs : dREN, dWEN, daddr, dstore   (dcache request)
//            iREN, iaddr                 (icache request)
//            ramload, ramstate           (RAM response)
//   outputs: dwait, dload, iwait, iload  (cache handshakes / read data)
//            ramREN, ramWEN, ramaddr, ramstore (RAM request)
//            ram_error                   (sticky RAM error flag)
// The master modport is the view of the surrounding caches and RAM.
// ramstate encoding: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
interface mem_arbiter_if;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ram_error;

    modport slave (
        input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
        output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore,
               ram_error
    );

    modport master (
        output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
        input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore,
               ram_error
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between the L1 dcache and icache.
//
// The dcache has priority. Every grant passes through IDLE first, so one
// arbitration cycle precedes each access. An 8-bit saturating starvation
// counter tracks how long the icache has been waiting; once it reaches
// STARVE_LIMIT the icache wins the next arbitration.
//
// Ports:
//   CLK  - system clock, rising edge
//   nRST - asynchronous active-low reset
//   bus  - mem_arbiter_if.slave: cache requests/handshakes, RAM request and
//          response, sticky ram_error flag
//
// Parameters:
//   STARVE_LIMIT  - icache waiting cycles before it gets priority (1..255)
//   RAM_ERR_RETRY - 1: re-drive the same request after a RAM ERROR,
//                   0: abandon the grant and return to IDLE
module mem_arbiter #(
    parameter int STARVE_LIMIT  = 16,
    parameter bit RAM_ERR_RETRY = 1'b1
) (
    input logic          CLK,
    input logic          nRST,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_BUS = 2'd1,
        I_BUS = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

    state_t     state;
    state_t     next_state;
    logic [7:0] starve_cnt;
    logic       err_flag;

    logic d_req;
    logic i_req;
    logic ram_done;
    logic ram_err;

    assign d_req    = bus.dREN | bus.dWEN;
    assign i_req    = bus.iREN;
    assign ram_done = (bus.ramstate == RAM_ACCESS);
    assign ram_err  = (bus.ramstate == RAM_ERROR);

    // Next-state decode. Completion or withdrawal both return to IDLE; an
    // ERROR either keeps the grant (retry) or drops it.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (i_req && (starve_cnt >= STARVE_LIM)) next_state = I_BUS;
                else if (d_req)                          next_state = D_BUS;
                else if (i_req)                          next_state = I_BUS;
                else                                     next_state = IDLE;
            end
            D_BUS: begin
                if (ram_done || !d_req)             next_state = IDLE;
                else if (ram_err && !RAM_ERR_RETRY) next_state = IDLE;
                else                                next_state = D_BUS;
            end
            I_BUS: begin
                if (ram_done || !i_req)             next_state = IDLE;
                else if (ram_err && !RAM_ERR_RETRY) next_state = IDLE;
                else                                next_state = I_BUS;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= 8'd0;
            err_flag   <= 1'b0;
        end else begin
            state <= next_state;

            // Clearing on the grant wins over counting; while the icache
            // owns the bus it is not waiting, so the count holds.
            if ((next_state == I_BUS) && (state != I_BUS))
                starve_cnt <= 8'd0;
            else if (i_req && (state != I_BUS) && (starve_cnt != 8'hFF))
                starve_cnt <= starve_cnt + 8'd1;

            if ((state != IDLE) && ram_err)
                err_flag <= 1'b1;
        end
    end

    // Output decode from the registered state. Only the bus owner's
    // request reaches the RAM; the wait release also requires the request
    // to still be present so a withdrawn request never sees a wait=0 pulse.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'd0;
        bus.ramstore = 32'd0;
        bus.dwait    = 1'b1;
        bus.iwait    = 1'b1;
        unique case (state)
            D_BUS: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.dwait    = ~(ram_done & d_req);
            end
            I_BUS: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = bus.iREN;
                bus.iwait   = ~(ram_done & i_req);
            end
            default: ;
        endcase
    end

    assign bus.dload     = bus.ramload;
    assign bus.iload     = bus.ramload;
    assign bus.ram_error = err_flag;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter
// (STARVE_LIMIT=4, RAM_ERR_RETRY=1), plus hand-written sequences for
// starvation and reset in the middle of an access.
module tb_mem_arbiter;

    logic CLK;
    logic nRST;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .STARVE_LIMIT (4),
        .RAM_ERR_RETRY(1'b1)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam logic [1:0] FR = 2'd0;
    localparam logic [1:0] BS = 2'd1;
    localparam logic [1:0] AC = 2'd2;
    localparam logic [1:0] ER = 2'd3;

    typedef struct {
        string       name;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic        iren;
        logic [31:0] iaddr;
        logic [31:0] ramload;
        logic [1:0]  ramstate;
        logic        e_dwait;
        logic        e_iwait;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic void add(input string n,
                                input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] ds,
                                input logic ir, input logic [31:0] ia,
                                input logic [31:0] rl, input logic [1:0] rs,
                                input logic edw, input logic eiw,
                                input logic er, input logic ew,
                                input logic [31:0] ea, input logic [31:0] es,
                                input logic ee);
        vec_t v;
        v.name = n;  v.dren = dr; v.dwen = dw; v.daddr = da; v.dstore = ds;
        v.iren = ir; v.iaddr = ia; v.ramload = rl; v.ramstate = rs;
        v.e_dwait = edw; v.e_iwait = eiw; v.e_ren = er; v.e_wen = ew;
        v.e_addr = ea; v.e_store = es; v.e_err = ee;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] ds,
                         input logic ir, input logic [31:0] ia,
                         input logic [31:0] rl, input logic [1:0] rs);
        bus.dREN     = dr;
        bus.dWEN     = dw;
        bus.daddr    = da;
        bus.dstore   = ds;
        bus.iREN     = ir;
        bus.iaddr    = ia;
        bus.ramload  = rl;
        bus.ramstate = rs;
    endtask

    // Expected behaviour of the starvation sequence, one entry per cycle.
    logic [31:0] sv_addr  [8] = '{32'h0, 32'h700, 32'h0, 32'h700, 32'h0, 32'h80, 32'h0, 32'h700};
    logic        sv_dwait [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        sv_iwait [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        // ---------------- reset state ----------------
        nRST = 1'b0;
        drive(1'b1, 1'b1, 32'h123, 32'h456, 1'b1, 32'h789, 32'hA5A5A5A5, AC);
        #2;
        chk1 ("rst.ramREN",    bus.ramREN,    1'b0);
        chk1 ("rst.ramWEN",    bus.ramWEN,    1'b0);
        chk32("rst.ramaddr",   bus.ramaddr,   32'h0);
        chk32("rst.ramstore",  bus.ramstore,  32'h0);
        chk1 ("rst.dwait",     bus.dwait,     1'b1);
        chk1 ("rst.iwait",     bus.iwait,     1'b1);
        chk1 ("rst.ram_error", bus.ram_error, 1'b0);
        chk32("rst.starve",    32'(dut.starve_cnt), 32'h0);
        @(negedge CLK);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, FR);
        @(negedge CLK);
        nRST = 1'b1;

        // ---------------- vector table ----------------
        //   name        dR   dW   daddr    dstore  iR   iaddr   ramload        rs  dw   iw   rR   rW   addr     store   err
        add("idle",      0,   0,   32'h0,   32'h0,  0,   32'h0,  32'hDEADBEEF,  FR, 1,   1,   0,   0,   32'h0,   32'h0,  0);
        // dcache read, 0-latency RAM
        add("rd.req",    1,   0,   32'h100, 32'h0,  0,   32'h0,  32'hDEADBEEF,  AC, 1,   1,   0,   0,   32'h0,   32'h0,  0);
        add("rd.acc",    1,   0,   32'h100, 32'h0,  0,   32'h0,  32'hDEADBEEF,  AC, 0,   1,   1,   0,   32'h100, 32'h0,  0);
        add("rd.idle",   0,   0,   32'h0,   32'h0,  0,   32'h0,  32'hDEADBEEF,  FR, 1,   1,   0,   0,   32'h0,   32'h0,  0);
        // simultaneous dcache write + icache read, 2 BUSY cycles each
        add("sim.c0",    0,   1,   32'h200, 32'h5,  1,   32'h40, 32'h0,         FR, 1,   1,   0,   0,   32'h0,   32'h0,  0);
        add("sim.c1",    0,   1,   32'h200, 32'h5,  1,   32'h40, 32'h0,         BS, 1,   1,   0,   1,   32'h200, 32'h5,  0);
        add("sim.c2",    0,   1,   32'h200, 32'h5,  1,   32'h40, 32'h0,         BS, 1,   1,   0,   1,   32'h200, 32'h5,  0);
        add("sim.c3",    0,   1,   32'h200, 32'h5,  1,   32'h40, 32'h0,         AC, 0,   1,   0,   1,   32'h200, 32'h5,  0);
        add("sim.c4",    0,   0,   32'h0,   32'h0,  1,   32'h40, 32'h0,         FR, 1,   1,   0,   0,   32'h0,   32'h0,  0);
        // dcache request during I_BUS must not reach the RAM
        add("sim.c5",    0,   1,   32'h300, 32'h77, 1,   32'h40, 32'h0,         BS, 1,   1,   1,   0,   32'h40,  32'h0,  0);
        add("sim.c6",    0,   1,   32'h300, 32'h77, 1,   32'h40, 32'h0,         FR, 1,   1,   1,   0,   32'h40,  32'h0,  0);
        add("sim.c7",    0,   1,   32'h300, 32'h77, 1,   32'h40, 32'h12345678,  AC, 1,   0,   1,   0,   32'h40,  32'h0,  0);
        add("sim.c8",    0,   0,   32'h0,   32'h0,  0,   32'h0,  32'h0,         FR, 1,   1,   0,   0,   32'h0,   32'h0,  0);
        // withdrawal while BUSY
        add("wd.req",    1,   0,   32'h400, 32'h0,  0,   32'h0,  32'h0,         FR, 1,   1,   0,   0,   32'h0,   32'h0,  0);
        add("wd.busy",   1,   0,   32'h400, 32'h0,  0,   32'h0,  32'h0,         BS, 1,   1,   1,   0,   32'h400, 32'h0,  0);
        add("wd.drop",   0,   0,   32'h400, 32'h0,  0,   32'h0,  32'h0,         BS, 1,   1,   0,   0,   32'h400, 32'h0,  0);
        add("wd.idle",   0,   0,   32'h400, 32'h0,  0,   32'h0,  32'h0,         AC, 1,   1,   0,   0,   32'h0,   32'h0,  0);
        // RAM error with retry
        add("er.req",    1,   0,   32'h500, 32'h0,  0,   32'h0,  32'hCAFEF00D,  FR, 1,   1,   0,   0,   32'h0,   32'h0,  0);
        add("er.err",    1,   0,   32'h500, 32'h0,  0,   32'h0,  32'hCAFEF00D,  ER, 1,   1,   1,   0,   32'h500, 32'h0,  0);
        add("er.retry",  1,   0,   32'h500, 32'h0,  0,   32'h0,  32'hCAFEF00D,  BS, 1,   1,   1,   0,   32'h500, 32'h0,  1);
        add("er.acc",    1,   0,   32'h500, 32'h0,  0,   32'h0,  32'hCAFEF00D,  AC, 0,   1,   1,   0,   32'h500, 32'h0,  1);
        add("er.idle",   0,   0,   32'h0,   32'h0,  0,   32'h0,  32'h0,         FR, 1,   1,   0,   0,   32'h0,   32'h0,  1);
        // dREN & dWEN together is a write
        add("rw.req",    1,   1,   32'h600, 32'h9,  0,   32'h0,  32'h0,         FR, 1,   1,   0,   0,   32'h0,   32'h0,  1);
        add("rw.acc",    1,   1,   32'h600, 32'h9,  0,   32'h0,  32'h0,         AC, 0,   1,   0,   1,   32'h600, 32'h9,  1);
        add("rw.idle",   0,   0,   32'h0,   32'h0,  0,   32'h0,  32'h0,         FR, 1,   1,   0,   0,   32'h0,   32'h0,  1);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge CLK);
            drive(vecs[k].dren, vecs[k].dwen, vecs[k].daddr, vecs[k].dstore,
                  vecs[k].iren, vecs[k].iaddr, vecs[k].ramload, vecs[k].ramstate);
            #1;
            chk1 ({vecs[k].name, ".dwait"},     bus.dwait,     vecs[k].e_dwait);
            chk1 ({vecs[k].name, ".iwait"},     bus.iwait,     vecs[k].e_iwait);
            chk1 ({vecs[k].name, ".ramREN"},    bus.ramREN,    vecs[k].e_ren);
            chk1 ({vecs[k].name, ".ramWEN"},    bus.ramWEN,    vecs[k].e_wen);
            chk32({vecs[k].name, ".ramaddr"},   bus.ramaddr,   vecs[k].e_addr);
            chk32({vecs[k].name, ".ramstore"},  bus.ramstore,  vecs[k].e_store);
            chk1 ({vecs[k].name, ".ram_error"}, bus.ram_error, vecs[k].e_err);
            chk32({vecs[k].name, ".dload"},     bus.dload,     vecs[k].ramload);
            chk32({vecs[k].name, ".iload"},     bus.iload,     vecs[k].ramload);
        end

        // ---------------- starvation: dREN held, iREN waiting ----------------
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            drive(1'b1, 1'b0, 32'h700, 32'h0, 1'b1, 32'h80, 32'h0, AC);
            #1;
            if (c == 0) chk32("stv.cnt_start", 32'(dut.starve_cnt), 32'd0);
            if (c == 4) chk32("stv.cnt_limit", 32'(dut.starve_cnt), 32'd4);
            if (c == 5) chk32("stv.cnt_grant", 32'(dut.starve_cnt), 32'd0);
            chk32($sformatf("stv.c%0d.ramaddr", c), bus.ramaddr, sv_addr[c]);
            chk1 ($sformatf("stv.c%0d.dwait", c),   bus.dwait,   sv_dwait[c]);
            chk1 ($sformatf("stv.c%0d.iwait", c),   bus.iwait,   sv_iwait[c]);
        end
        @(negedge CLK);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, FR);

        // ---------------- reset in the middle of a BUSY dcache write ----------------
        @(negedge CLK);
        drive(1'b0, 1'b1, 32'h900, 32'h1, 1'b0, 32'h0, 32'h0, BS);
        @(negedge CLK);
        #1;
        chk1 ("mrst.pre.ramWEN",    bus.ramWEN,    1'b1);
        chk1 ("mrst.pre.ram_error", bus.ram_error, 1'b1);
        #2;
        nRST = 1'b0;
        #1;
        chk1 ("mrst.ramWEN",    bus.ramWEN,    1'b0);
        chk1 ("mrst.dwait",     bus.dwait,     1'b1);
        chk1 ("mrst.ram_error", bus.ram_error, 1'b0);
        chk32("mrst.ramaddr",   bus.ramaddr,   32'h0);
        chk32("mrst.ramstore",  bus.ramstore,  32'h0);
        @(negedge CLK);
        #1;
        chk1 ("mrst.hold.ramWEN", bus.ramWEN, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, FR);
        nRST = 1'b1;
        @(negedge CLK);
        #1;
        chk1 ("mrst.after.ramREN", bus.ramREN, 1'b0);
        chk1 ("mrst.after.dwait",  bus.dwait,  1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
